// File: rtl/pdm_cic_decimator_if.sv
// Purpose : PDM microphone input / PCM sample output bundle of the CIC decimator.
// Latency : n/a (wires only).
// Backpr. : none; samples are strobed with sample_valid and never stalled.
//
// Signals:
//   pdm_clk_en   PDM bit clock as a level; a rising edge marks a valid bit
//   pdm_data     PDM bit
//   pdm_clk      generated microphone clock (tied low unless generated)
//   sample_out   signed decimated PCM sample, holds between updates
//   sample_valid one-clock strobe when sample_out updates
// master = microphone / sample consumer side, slave = the decimator.
interface pdm_cic_decimator_if #(
    parameter int OUT_WIDTH = 16
);
    logic                        pdm_clk_en;
    logic                        pdm_data;
    logic                        pdm_clk;
    logic signed [OUT_WIDTH-1:0] sample_out;
    logic                        sample_valid;

    modport master (
        output pdm_clk_en,
        output pdm_data,
        input  pdm_clk,
        input  sample_out,
        input  sample_valid
    );

    modport slave (
        input  pdm_clk_en,
        input  pdm_data,
        output pdm_clk,
        output sample_out,
        output sample_valid
    );
endinterface

// File: rtl/pdm_cic_decimator.sv
// Purpose : N-stage CIC decimator turning a 1-bit PDM stream into signed PCM samples.
// Latency : sample_valid rises N_STAGES+2 clk after the decimating bit strobe.
// Backpr. : none; one-cycle sample_valid strobe, sample_out holds until next update.
//
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   bus (slave) pdm_clk_en / pdm_data in, pdm_clk / sample_out / sample_valid out
// Optional feature macro: PDM_CLK_GEN_EN -- when defined, pdm_clk is generated
// internally (period 2*CLK_DIV clk), bits are taken on its rising edge and
// pdm_clk_en is ignored. When undefined, pdm_clk is tied low and bits are taken
// on the synchronised rising edge of pdm_clk_en.
module pdm_cic_decimator #(
    parameter int N_STAGES  = 4,
    parameter int DECIM     = 64,
    parameter int OUT_WIDTH = 16,
    parameter int CLK_DIV   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    pdm_cic_decimator_if.slave bus
);
    localparam int LOG2D     = $clog2(DECIM);
    localparam int ACC_WIDTH = N_STAGES * LOG2D + 2;
    // Right shift bringing full scale (2^(N*log2 D)) to 2^(OUT_WIDTH-1);
    // split into left/right parts so small configurations still elaborate.
    localparam int SHIFT     = N_STAGES * LOG2D + 1 - OUT_WIDTH;
    localparam int RSH       = (SHIFT > 0) ? SHIFT : 0;
    localparam int LSH       = (SHIFT < 0) ? -SHIFT : 0;
    localparam int EXT_W     = ACC_WIDTH + OUT_WIDTH;

    localparam logic signed [EXT_W-1:0] SAT_MAX =
        {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN =
        {{(EXT_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    if (N_STAGES < 1 || N_STAGES > 6 || DECIM < 8 || DECIM > 256 ||
        (DECIM & (DECIM - 1)) != 0 || CLK_DIV < 1) begin : g_param_check
        $error("pdm_cic_decimator: illegal parameter set");
    end

    typedef logic signed [ACC_WIDTH-1:0] acc_t;
    typedef enum logic [1:0] {ST_IDLE, ST_COMB, ST_OUT} state_t;

    acc_t                  integ_q    [N_STAGES];
    acc_t                  integ_d    [N_STAGES];
    acc_t                  comb_dly_q [N_STAGES];
    acc_t                  comb_dly_d [N_STAGES];
    acc_t                  comb_val_q, comb_val_d;
    logic [LOG2D-1:0]      dec_cnt_q, dec_cnt_d;
    logic [2:0]            settle_q, settle_d;
    logic [2:0]            stg_q, stg_d;
    state_t                state_q, state_d;
    logic signed [OUT_WIDTH-1:0] sample_out_q, sample_out_d;
    logic                  sample_valid_q, sample_valid_d;

`ifdef PDM_CLK_GEN_EN
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic                  pdm_clk_q, pdm_clk_d;
`else
    // [0],[1] form the 2-FF synchroniser, [2] is the previous level for edge detect
    logic [2:0]            sync_q, sync_d;
    // pdm_data follows the same two flops so it stays aligned with bit_stb
    logic [1:0]            dsync_q, dsync_d;
`endif

    logic                  bit_stb;
    logic                  bit_dat;
    logic                  dec_stb;
    acc_t                  x_in;
    logic signed [EXT_W-1:0] ext;

    always_comb begin
        integ_d        = integ_q;
        comb_dly_d     = comb_dly_q;
        comb_val_d     = comb_val_q;
        dec_cnt_d      = dec_cnt_q;
        settle_d       = settle_q;
        stg_d          = stg_q;
        state_d        = state_q;
        sample_out_d   = sample_out_q;
        sample_valid_d = 1'b0;
        dec_stb        = 1'b0;
        ext            = '0;

`ifdef PDM_CLK_GEN_EN
        div_cnt_d = div_cnt_q + 1'b1;
        pdm_clk_d = pdm_clk_q;
        if (div_cnt_q == DIV_W'(CLK_DIV - 1)) begin
            div_cnt_d = '0;
            pdm_clk_d = ~pdm_clk_q;
        end
        bit_stb = (div_cnt_q == DIV_W'(CLK_DIV - 1)) && !pdm_clk_q;
        bit_dat = bus.pdm_data;
`else
        sync_d  = {sync_q[1], sync_q[0], bus.pdm_clk_en};
        dsync_d = {dsync_q[0], bus.pdm_data};
        bit_stb = sync_q[1] & ~sync_q[2];
        bit_dat = dsync_q[1];
`endif

        x_in = bit_dat ? acc_t'(1) : {ACC_WIDTH{1'b1}};

        // Integrator chain: each stage adds the registered value of the one
        // before it; wrap-around is intended.
        if (bit_stb) begin
            integ_d[0] = integ_q[0] + x_in;
            for (int k = 1; k < N_STAGES; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
            dec_cnt_d = dec_cnt_q + 1'b1;
            dec_stb   = (dec_cnt_q == {LOG2D{1'b1}});
        end

        case (state_q)
            ST_IDLE: begin
                if (dec_stb) begin
                    comb_val_d = integ_q[N_STAGES-1];
                    stg_d      = '0;
                    state_d    = ST_COMB;
                end
            end
            ST_COMB: begin
                // One comb stage per clk, selected by stg_q
                for (int k = 0; k < N_STAGES; k++) begin
                    if (stg_q == 3'(k)) begin
                        comb_val_d    = comb_val_q - comb_dly_q[k];
                        comb_dly_d[k] = comb_val_q;
                    end
                end
                if (stg_q == 3'(N_STAGES - 1)) begin
                    state_d = ST_OUT;
                end else begin
                    stg_d = stg_q + 1'b1;
                end
            end
            ST_OUT: begin
                state_d = ST_IDLE;
                ext = {{(EXT_W-ACC_WIDTH){comb_val_q[ACC_WIDTH-1]}}, comb_val_q};
                ext = ext <<< LSH;
                ext = ext >>> RSH;
                // The first N_STAGES results still carry start-up transient
                if (settle_q == 3'(N_STAGES)) begin
                    sample_valid_d = 1'b1;
                    if (ext > SAT_MAX) begin
                        sample_out_d = SAT_MAX[OUT_WIDTH-1:0];
                    end else if (ext < SAT_MIN) begin
                        sample_out_d = SAT_MIN[OUT_WIDTH-1:0];
                    end else begin
                        sample_out_d = ext[OUT_WIDTH-1:0];
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_STAGES; k++) begin
                integ_q[k]    <= '0;
                comb_dly_q[k] <= '0;
            end
            comb_val_q     <= '0;
            dec_cnt_q      <= '0;
            settle_q       <= '0;
            stg_q          <= '0;
            state_q        <= ST_IDLE;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
`ifdef PDM_CLK_GEN_EN
            div_cnt_q      <= '0;
            pdm_clk_q      <= 1'b0;
`else
            sync_q         <= '0;
            dsync_q        <= '0;
`endif
        end else begin
            integ_q        <= integ_d;
            comb_dly_q     <= comb_dly_d;
            comb_val_q     <= comb_val_d;
            dec_cnt_q      <= dec_cnt_d;
            settle_q       <= settle_d;
            stg_q          <= stg_d;
            state_q        <= state_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
`ifdef PDM_CLK_GEN_EN
            div_cnt_q      <= div_cnt_d;
            pdm_clk_q      <= pdm_clk_d;
`else
            sync_q         <= sync_d;
            dsync_q        <= dsync_d;
`endif
        end
    end

    assign bus.sample_out   = sample_out_q;
    assign bus.sample_valid = sample_valid_q;
`ifdef PDM_CLK_GEN_EN
    assign bus.pdm_clk      = pdm_clk_q;
`else
    assign bus.pdm_clk      = 1'b0;
`endif
endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Purpose : scoreboard bench for pdm_cic_decimator (default build, PDM clock external).
// Latency : expects each sample 2 sync clk + N_STAGES+2 clk after its wrapping bit edge.
// Backpr. : none; the monitor pops one expected entry per sample_valid strobe.
module tb_pdm_cic_decimator;
    localparam int N = 4;
    localparam int D = 64;
    // pdm_clk_en driven at a negedge is sampled by the next posedge (1), reaches
    // the second sync flop one clk later (2), then N_STAGES+2 to sample_valid.
    localparam int LAT = 2 + N + 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pdm_cic_decimator_if #(.OUT_WIDTH(16)) bus ();

    pdm_cic_decimator #(
        .N_STAGES (N),
        .DECIM    (D),
        .OUT_WIDTH(16),
        .CLK_DIV  (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   bit_cnt = 0;
    int   cur_exp = 0;
    int   n_samples = 0;
    logic prev_vld = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every strobe
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld = 1'b0;
        end else begin
            if (bus.sample_valid) begin
                n_samples++;
                check("valid_pulse_width", int'(prev_vld), 0);
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_sample: got value %0d, required no strobe (cycle %0d)",
                             int'(bus.sample_out), cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sample_value", int'(bus.sample_out), e.val);
                    check("sample_latency", cyc - e.cyc, LAT);
                end
            end
            prev_vld = bus.sample_valid;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_sample_out", int'(bus.sample_out), 0);
        check("rst_sample_valid", int'(bus.sample_valid), 0);
        check("rst_pdm_clk", int'(bus.pdm_clk), 0);
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        bit_cnt = 0;
        sb.delete();
    endtask

    task automatic send_bit(input logic b, input int hi, input int lo);
        @(negedge clk);
        bus.pdm_data   = b;
        bus.pdm_clk_en = 1'b1;
        if ((bit_cnt % D) == D - 1 && (bit_cnt / D) >= N) begin
            exp_t e;
            e.val = cur_exp;
            e.cyc = cyc;
            sb.push_back(e);
        end
        // Well past the last suppressed result: output must still be zero
        if (bit_cnt == N * D + 8) begin
            check("suppressed_out_zero", int'(bus.sample_out), 0);
        end
        repeat (hi) @(negedge clk);
        bus.pdm_clk_en = 1'b0;
        repeat (lo - 1) @(negedge clk);
        bit_cnt++;
    endtask

    task automatic finish_phase(input string name, input int pulses_req, input int start_cnt);
        repeat (20) @(negedge clk);
        check({name, "_missing_samples"}, sb.size(), 0);
        check({name, "_pulse_count"}, n_samples - start_cnt, pulses_req);
        sb.delete();
    endtask

    initial begin
        int s0;
        rst_n          = 1'b0;
        bus.pdm_clk_en = 1'b0;
        bus.pdm_data   = 1'b0;
        repeat (2) @(negedge clk);
        check("init_sample_out", int'(bus.sample_out), 0);
        check("init_sample_valid", int'(bus.sample_valid), 0);
        check("init_pdm_clk", int'(bus.pdm_clk), 0);

        // Positive full scale: 6 frames, first 4 suppressed
        do_reset();
        cur_exp = 32767;
        s0 = n_samples;
        for (int i = 0; i < (N + 2) * D; i++) send_bit(1'b1, 3, 3);
        finish_phase("pos_fs", 2, s0);

        // Negative full scale
        do_reset();
        cur_exp = -32768;
        s0 = n_samples;
        for (int i = 0; i < (N + 2) * D; i++) send_bit(1'b0, 3, 3);
        finish_phase("neg_fs", 2, s0);

        // Zero input: alternating bits, 10 frames -> 6 settled zeros
        do_reset();
        cur_exp = 0;
        s0 = n_samples;
        for (int i = 0; i < 10 * D; i++) send_bit((i % 2) == 0, 3, 3);
        finish_phase("zero", 6, s0);

        // Long-level edge detection: 20 clk high / 20 low per bit
        do_reset();
        cur_exp = 32767;
        s0 = n_samples;
        for (int i = 0; i < (N + 2) * D; i++) send_bit(1'b1, 20, 20);
        finish_phase("edge", 2, s0);

        // Reset halfway through frame index 10
        do_reset();
        cur_exp = 32767;
        s0 = n_samples;
        for (int i = 0; i < 10 * D + D / 2; i++) send_bit(1'b1, 3, 3);
        check("pre_reset_out", int'(bus.sample_out), 32767);
        check("pre_reset_pulse_count", n_samples - s0, 6);
        check("pre_reset_missing", sb.size(), 0);
        do_reset();
        cur_exp = -32768;
        s0 = n_samples;
        for (int i = 0; i < (N + 2) * D; i++) send_bit(1'b0, 3, 3);
        finish_phase("post_reset", 2, s0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pdm_cic_decimator.md
Name: pdm_cic_decimator

Overview:
- Front-end stage directly upstream of the 30-tap FIR low-pass filter.
- Converts the 1-bit PDM stream from the microphone into signed 16-bit PCM samples using an N-stage CIC integrator/comb decimator.
- Samples are delivered at fs_pdm/DECIM with a single-cycle strobe, which the FIR's enable edge detector consumes.
- Runs on the fast system clock; the PDM bit clock (3 MHz, 780 kHz, ...) arrives as a slow level signal and is edge-detected internally.

Parameters:
- N_STAGES, 4: CIC order, i.e. the number of integrator and comb stages (1..6).
- DECIM, 64: decimation ratio; must be a power of two, 8..256.
- OUT_WIDTH, 16: output sample width.
- CLK_DIV, 16: half-period of the generated PDM clock, in clk cycles. Used only with PDM_CLK_GEN_EN.
- Derived, ACC_WIDTH = N_STAGES*log2(DECIM)+2 (26 at defaults): two's-complement width of every integrator and comb register.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- pdm_clk_en  input  1  PDM bit clock as a level signal; a rising edge marks a valid pdm_data bit.
- pdm_data  input  1  PDM bit.
- pdm_clk  output  1  generated microphone clock (see Optional Feature).
- sample_out  output  OUT_WIDTH signed  decimated PCM sample.
- sample_valid  output  1  one-clk strobe when sample_out updates.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n low clears all integrators, comb delay registers, the decimation counter, the settle counter, the pipeline and the edge synchroniser.
  - Outputs during and after reset: sample_out=0, sample_valid=0, pdm_clk=0.
  - Asserting rst_n mid-frame aborts the frame and any in-flight comb pipeline; no strobe is emitted.
- Edge detection:
  - pdm_clk_en passes through a 2-FF synchroniser, then a rising-edge detector producing bit_stb, one clk wide.
  - A level held high for many cycles counts as exactly one edge.
- Input mapping: on bit_stb, pdm_data=1 maps to +1 and pdm_data=0 maps to -1, sign-extended to ACC_WIDTH.
- Integrators:
  - All N_STAGES cascaded integrators update on bit_stb only.
  - Integrator k adds the registered output of stage k-1.
  - Arithmetic is modulo 2^ACC_WIDTH; wrap-around is allowed and required, and no saturation is applied inside the CIC.
- Decimation counter:
  - Counts 0..DECIM-1 on bit_stb.
  - On the bit_stb where it wraps from DECIM-1 to 0, the final integrator value is captured into the comb pipeline (dec_stb).
- Comb pipeline:
  - N_STAGES registered stages, one clk per stage: y_k = x_k - x_k_prev (differential delay 1), modulo 2^ACC_WIDTH.
  - A state machine sequences the pipeline: IDLE -> COMB (N_STAGES cycles) -> OUT (1 cycle) -> IDLE.
  - A new dec_stb cannot occur while COMB is active, because DECIM bit_stb are always much more than N_STAGES+2 clk apart.
- Output scaling:
  - Full-scale CIC value is ±2^(N_STAGES*log2(DECIM)).
  - sample_out = comb_out >>> (N_STAGES*log2(DECIM)+1-OUT_WIDTH), i.e. an arithmetic shift by 9 at defaults.
  - The result saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], so +full scale reads 32767 and -full scale reads -32768.
- Latency: sample_out and sample_valid update N_STAGES+2 clk after the dec_stb cycle. sample_valid is high for exactly 1 clk; sample_out holds until the next update.
- Settling:
  - The first N_STAGES decimated results after reset are computed but suppressed: sample_valid stays 0 and sample_out stays 0.
  - A 3-bit settle counter saturates at N_STAGES.
- Simultaneous events: a bit_stb arriving in the same clk as the OUT state is processed normally; the integrators and pipeline are independent.

Optional Feature:
- Macro: PDM_CLK_GEN_EN.
- Defined:
  - An internal counter toggles pdm_clk every CLK_DIV clk, giving a period of 2*CLK_DIV.
  - bit_stb is taken from the internal rising edge of pdm_clk, with no synchroniser.
  - pdm_clk_en is ignored.
  - pdm_clk resets to 0 and starts toggling after rst_n rises.
- Undefined: pdm_clk is tied to 0 and bit_stb comes from the synchronised pdm_clk_en.

Test Plan:
- Settling and positive full scale: pdm_data=1 held for (N_STAGES+2)*DECIM = 384 edges -> exactly 2 sample_valid pulses, both with sample_out=32767. No pulse occurs during the first 4 frames.
- Negative full scale: pdm_data=0 held for 384 edges -> settled samples read -32768.
- Zero input: alternating 1,0 bits for 640 edges -> every settled sample_out = 0.
- Edge detection: pdm_clk_en high for 20 clk and low for 20 clk per bit, 64*6 bits of 1 -> same result as the positive full-scale case. Each long-high level counts exactly one bit.
- Latency and pulse width: measure from the wrapping bit_stb to sample_valid -> 6 clk at defaults. sample_valid is 1 clk wide.
- Reset mid-operation: assert rst_n=0 for 3 clk halfway through frame 10 -> sample_valid and sample_out drop to 0 immediately. After release, 4 frames are suppressed again, then correct values resume.
